// File: rtl/io_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_arb_pkg
// Brief    : Shared types and constants for the two-requester I/O arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic REQ_LSU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int IO_AW = 4;
    localparam int IO_DW = 16;

endpackage
`default_nettype wire

// File: rtl/io_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : io_rr_pick
// Brief    : Combinational two-way round-robin selector.
// Revision : 1.0 - initial release
// ============================================================================
module io_rr_pick
    import io_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_valid,
    output logic o_id
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        // On a tie the requester that was not served last wins.
        if (i_req0 && i_req1) begin
            o_id = ~i_last;
        end else if (i_req1) begin
            o_id = REQ_DBG;
        end else begin
            o_id = REQ_LSU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : io_arbiter
// Brief    : Round-robin arbiter with lock and wait states for the I/O port.
// Revision : 1.0 - initial release
// ============================================================================
module io_arbiter
    import io_arb_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int MAX_LOCK    = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ0,
    input  logic                 REQ1,
    input  logic                 WE0,
    input  logic                 WE1,
    input  logic [IO_AW-1:0]     A0,
    input  logic [IO_AW-1:0]     A1,
    input  logic [IO_DW-1:0]     D0,
    input  logic [IO_DW-1:0]     D1,
    input  logic                 LOCK0,
    input  logic                 LOCK1,
    output logic                 ACK0,
    output logic                 ACK1,
    output logic [IO_DW-1:0]     Q0,
    output logic [IO_DW-1:0]     Q1,
    output logic [IO_AW-1:0]     IOA,
    output logic [31:0]          IOD,
    output logic                 IOE,
    input  logic [31:0]          IOQ,
    output logic                 BUSY
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);
    localparam logic [3:0] LOCK_MAX  = 4'(MAX_LOCK);
    localparam logic       WAIT_ZERO = (WAIT_STATES == 0);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0]         lock_cnt_q, lock_cnt_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic               we_q, we_d;
    logic [IO_AW-1:0]   addr_q, addr_d;
    logic [IO_DW-1:0]   wdata_q, wdata_d;
    logic [IO_DW-1:0]   q0_q, q0_d;
    logic [IO_DW-1:0]   q1_q, q1_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               ioe_q, ioe_d;
    logic               busy_q, busy_d;

    logic               pick_valid;
    logic               pick_id;
    logic               sel_id;
    logic               sel_we;
    logic [IO_AW-1:0]   sel_addr;
    logic [IO_DW-1:0]   sel_wdata;
    logic               own_req;
    logic               own_lock;
    logic               other_req;
    logic               unused_ioq_hi;

    assign unused_ioq_hi = ^IOQ[31:IO_DW];

    io_rr_pick u_pick (
        .i_req0  (REQ0),
        .i_req1  (REQ1),
        .i_last  (last_q),
        .o_valid (pick_valid),
        .o_id    (pick_id)
    );

    // Fresh grants latch the picked requester; locked re-grants the owner.
    assign sel_id    = (state_q == IDLE) ? pick_id : owner_q;
    assign sel_we    = sel_id ? WE1 : WE0;
    assign sel_addr  = sel_id ? A1  : A0;
    assign sel_wdata = sel_id ? D1  : D0;
    assign own_req   = owner_q ? REQ1  : REQ0;
    assign own_lock  = owner_q ? LOCK1 : LOCK0;
    assign other_req = owner_q ? REQ0  : REQ1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lock_cnt_d = lock_cnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        q0_d       = q0_q;
        q1_d       = q1_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        ioe_d      = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_id;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                    busy_d  = 1'b1;
                    ioe_d   = sel_we & WAIT_ZERO;
                end
            end
            ACCESS: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q == REQ_DBG) begin
                            q1_d = IOQ[IO_DW-1:0];
                        end else begin
                            q0_d = IOQ[IO_DW-1:0];
                        end
                    end
                    ack0_d = (owner_q == REQ_LSU);
                    ack1_d = (owner_q == REQ_DBG);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    ioe_d = we_q & ((cnt_q + 4'd1) == WAIT_LAST);
                end
            end
            DONE: begin
                last_d = owner_q;
                // The lock budget is only consumed while the other side waits.
                if (own_lock && own_req && (lock_cnt_q < LOCK_MAX)) begin
                    we_d       = sel_we;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    lock_cnt_d = lock_cnt_q + {3'b000, other_req};
                    cnt_d      = 4'd0;
                    state_d    = ACCESS;
                    ioe_d      = sel_we & WAIT_ZERO;
                end else begin
                    lock_cnt_d = 4'd0;
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            lock_cnt_q <= 4'd0;
            owner_q    <= REQ_LSU;
            last_q     <= REQ_DBG;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            q0_q       <= '0;
            q1_q       <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            ioe_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lock_cnt_q <= lock_cnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            ioe_q      <= ioe_d;
            busy_q     <= busy_d;
        end
    end

    assign ACK0 = ack0_q;
    assign ACK1 = ack1_q;
    assign Q0   = q0_q;
    assign Q1   = q1_q;
    assign IOA  = addr_q;
    assign IOD  = {16'b0, wdata_q};
    assign IOE  = ioe_q;
    assign BUSY = busy_q;

endmodule
`default_nettype wire
